l1_dcache: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's MEM stage and the L2 cache. It serves 32-bit word reads and writes with zero stall on a hit. On a miss it holds the pipeline with `proc_stall`, writes back a dirty victim line and fills the line from L2. All L2 transfers use 128-bit lines over L2's `read`/`write`/`ready` handshake.

---
 rtl/cache_pkg.sv | 15 +
 rtl/l1_tag_array.sv | 40 ++++
 rtl/l1_dcache.sv | 99 +++++++++
 tb/tb_l1_dcache.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, geometry constants and address field helpers for the L1 data cache
package cache_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;
    localparam int WORD_W = 32;
    localparam int LINE_W = 128;
    localparam int WORDS_PER_LINE = 4;
    function automatic logic [29:0] addr_index(input logic [29:0] addr, input int index_w);
        return (addr >> 2) & ((30'd1 << index_w) - 30'd1);
    endfunction
    function automatic logic [29:0] addr_tag(input logic [29:0] addr, input int index_w);
        return addr >> (index_w + 2);
    endfunction
endpackage

// File: rtl/l1_tag_array.sv
// l1_tag_array: per-line tag/valid/dirty storage, hit detection and victim tag lookup
module l1_tag_array
    import cache_pkg::*;
#(
    parameter int ENTRY   = 8,
    parameter int INDEX_W = $clog2(ENTRY),
    parameter int TAGLEN  = 28 - INDEX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] idx,
    input  logic [TAGLEN-1:0]  tag,
    input  logic               fill,
    input  logic               set_dirty,
    input  logic               clr_dirty,
    output logic               hit,
    output logic               dirty,
    output logic [TAGLEN-1:0]  victim_tag
);
    logic [TAGLEN-1:0] tags [ENTRY];
    logic [ENTRY-1:0]  valid, dirty_q;
    assign hit        = valid[idx] && tags[idx] == tag;
    assign dirty      = dirty_q[idx];
    assign victim_tag = tags[idx];
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= '0;
            dirty_q <= '0;
            for (int i = 0; i < ENTRY; i++) tags[i] <= '0;
        end else if (fill) begin
            tags[idx]    <= tag;
            valid[idx]   <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (set_dirty) begin
            dirty_q[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_q[idx] <= 1'b0;
        end
    end
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back write-allocate L1 data cache; L1_PERF_CNT_EN adds access/miss counters
module l1_dcache
    import cache_pkg::*;
#(
    parameter int ENTRY   = 8,
    parameter int INDEX_W = $clog2(ENTRY),
    parameter int TAGLEN  = 28 - INDEX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          proc_read,
    input  logic          proc_write,
    input  logic [29:0]   proc_addr,
    input  logic [31:0]   proc_wdata,
    output logic [31:0]   proc_rdata,
    output logic          proc_stall,
    output logic          l2_read,
    output logic          l2_write,
    output logic [29:0]   l2_addr,
    output logic [127:0]  l2_wdata,
    input  logic [127:0]  l2_rdata,
`ifdef L1_PERF_CNT_EN
    input  logic          l2_ready,
    output logic [15:0]   cnt_access,
    output logic [15:0]   cnt_miss
`else
    input  logic          l2_ready
`endif
);
    logic [1:0]         state, state_nx;
    logic [LINE_W-1:0]  data [ENTRY];
    logic [INDEX_W-1:0] idx;
    logic [TAGLEN-1:0]  tag, victim_tag;
    logic [1:0]         word;
    logic [LINE_W-1:0]  line;
    logic               hit, dirty, req, idle, hit_wr, fill, wb_done;
    assign idx     = INDEX_W'(addr_index(proc_addr, INDEX_W));
    assign tag     = TAGLEN'(addr_tag(proc_addr, INDEX_W));
    assign word    = proc_addr[1:0];
    assign line    = data[idx];
    assign req     = proc_read || proc_write;
    assign idle    = state == S_IDLE;
    assign hit_wr  = idle && req && hit && proc_write;
    assign fill    = state == S_ALLOC && l2_ready;
    assign wb_done = state == S_WB && l2_ready;

    l1_tag_array #(.ENTRY(ENTRY), .INDEX_W(INDEX_W), .TAGLEN(TAGLEN)) u_tags (
        .clk        (clk),
        .reset      (reset),
        .idx        (idx),
        .tag        (tag),
        .fill       (fill),
        .set_dirty  (hit_wr),
        .clr_dirty  (wb_done),
        .hit        (hit),
        .dirty      (dirty),
        .victim_tag (victim_tag)
    );

    always_comb begin
        state_nx = (state == S_IDLE)  ? ((req && !hit) ? (dirty ? S_WB : S_ALLOC) : S_IDLE) :
                   (state == S_WB)    ? (l2_ready ? S_ALLOC : S_WB) :
                   (state == S_ALLOC) ? (l2_ready ? S_IDLE : S_ALLOC) : S_IDLE;
    end

    // L2-side outputs come only from the registered state, never from the hit/miss path
    assign proc_stall = !reset && ((idle && req && !hit) || state == S_WB || state == S_ALLOC);
    assign proc_rdata = (!reset && idle && proc_read && !proc_write && hit) ? line[{word, 5'd0} +: WORD_W] : '0;
    assign l2_write   = !reset && state == S_WB;
    assign l2_read    = !reset && state == S_ALLOC;
    assign l2_addr    = l2_write ? {victim_tag, idx, 2'b00} : l2_read ? {proc_addr[29:2], 2'b00} : '0;
    assign l2_wdata   = l2_write ? line : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            for (int i = 0; i < ENTRY; i++) data[i] <= '0;
        end else begin
            state <= state_nx;
            if (fill) data[idx] <= l2_rdata;
            else if (hit_wr) data[idx][{word, 5'd0} +: WORD_W] <= proc_wdata;
        end
    end

`ifdef L1_PERF_CNT_EN
    logic refill;
    always_ff @(posedge clk) begin
        if (reset) begin
            refill     <= 1'b0;
            cnt_access <= '0;
            cnt_miss   <= '0;
        end else begin
            refill <= fill;
            if (idle && req && !refill) cnt_access <= cnt_access + 16'd1;
            if (idle && req && !hit) cnt_miss <= cnt_miss + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed self-checking bench for l1_dcache (default build)
module tb_l1_dcache;
    logic         clk = 1'b0;
    logic         reset, proc_read, proc_write, l2_ready;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall, l2_read, l2_write;
    logic [29:0]  l2_addr;
    logic [127:0] l2_wdata, l2_rdata;
    int passed = 0, total = 0, stalls = 0;

    localparam logic [127:0] LINE_A  = 128'h44443333_22221111_0000FFFF_12345678;
    localparam logic [127:0] LINE_A2 = 128'h44443333_DEADBEEF_0000FFFF_12345678;
    localparam logic [127:0] LINE_B  = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;

    always #5 clk = ~clk;

    l1_dcache dut (
        .clk        (clk),
        .reset      (reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_addr    (l2_addr),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_ready   (l2_ready)
    );

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    initial begin
        reset = 1'b1; proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h10;
        proc_wdata = '0; l2_ready = 1'b0; l2_rdata = '0;
        @(negedge clk); #1;
        chk("rst_stall", 128'(proc_stall), 128'd0);
        chk("rst_l2read", 128'(l2_read), 128'd0);
        chk("rst_rdata", 128'(proc_rdata), 128'd0);
        // clean miss with L=0
        @(negedge clk); reset = 1'b0; #1;
        chk("miss0_stall", 128'(proc_stall), 128'd1);
        chk("miss0_idle_l2read", 128'(l2_read), 128'd0);
        @(negedge clk); l2_ready = 1'b1; l2_rdata = LINE_A; #1;
        chk("alloc0_l2read", 128'(l2_read), 128'd1);
        chk("alloc0_l2write", 128'(l2_write), 128'd0);
        chk("alloc0_addr", 128'(l2_addr), 128'h10);
        chk("alloc0_stall", 128'(proc_stall), 128'd1);
        @(negedge clk); l2_ready = 1'b0; #1;
        chk("fill0_stall", 128'(proc_stall), 128'd0);
        chk("fill0_rdata", 128'(proc_rdata), 128'h12345678);
        @(negedge clk); proc_addr = 30'h11; #1;
        chk("hit11_stall", 128'(proc_stall), 128'd0);
        chk("hit11_rdata", 128'(proc_rdata), 128'h0000FFFF);
        @(negedge clk); proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h12; proc_wdata = 32'hDEADBEEF; #1;
        chk("wr12_stall", 128'(proc_stall), 128'd0);
        @(negedge clk); proc_write = 1'b0; proc_read = 1'b1; #1;
        chk("rd12_stall", 128'(proc_stall), 128'd0);
        chk("rd12_rdata", 128'(proc_rdata), 128'hDEADBEEF);
        @(negedge clk); proc_read = 1'b0; #1;
        chk("noreq_stall", 128'(proc_stall), 128'd0);
        chk("noreq_l2", 128'({l2_read, l2_write, l2_addr}), 128'd0);
        // dirty conflict miss, W=1, L=5
        @(negedge clk); proc_read = 1'b1; proc_addr = 30'h32; #1;
        stalls += int'(proc_stall);
        chk("dm_idle_stall", 128'(proc_stall), 128'd1);
        chk("dm_idle_l2write", 128'(l2_write), 128'd0);
        @(negedge clk); #1;
        stalls += int'(proc_stall);
        chk("wb_l2write", 128'(l2_write), 128'd1);
        chk("wb_l2read", 128'(l2_read), 128'd0);
        chk("wb_addr", 128'(l2_addr), 128'h10);
        chk("wb_word2", 128'(l2_wdata[95:64]), 128'hDEADBEEF);
        @(negedge clk); l2_ready = 1'b1; #1;
        stalls += int'(proc_stall);
        chk("wb_l2write2", 128'(l2_write), 128'd1);
        @(negedge clk); l2_ready = 1'b0; #1;
        stalls += int'(proc_stall);
        chk("al_l2read", 128'(l2_read), 128'd1);
        chk("al_l2write", 128'(l2_write), 128'd0);
        chk("al_addr", 128'(l2_addr), 128'h30);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            stalls += int'(proc_stall);
            chk("al_hold", 128'({l2_read, proc_stall}), 128'd3);
        end
        @(negedge clk); l2_ready = 1'b1; l2_rdata = LINE_B; #1;
        stalls += int'(proc_stall);
        chk("al_done_l2read", 128'(l2_read), 128'd1);
        @(negedge clk); l2_ready = 1'b0; #1;
        chk("dm_stall_end", 128'(proc_stall), 128'd0);
        chk("dm_rdata", 128'(proc_rdata), 128'hAAAA0002);
        chk("dm_stall_cycles", 128'(stalls), 128'd9);
        // refetch the evicted line: victim is clean so no writeback
        @(negedge clk); proc_addr = 30'h12; #1;
        chk("rf_stall", 128'(proc_stall), 128'd1);
        @(negedge clk); l2_ready = 1'b1; l2_rdata = LINE_A2; #1;
        chk("rf_l2read", 128'(l2_read), 128'd1);
        chk("rf_l2write", 128'(l2_write), 128'd0);
        chk("rf_addr", 128'(l2_addr), 128'h10);
        @(negedge clk); l2_ready = 1'b0; #1;
        chk("rf_rdata", 128'(proc_rdata), 128'hDEADBEEF);
        // reset in the middle of a writeback
        @(negedge clk); proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h13; proc_wdata = 32'h5555AAAA; #1;
        chk("wr13_stall", 128'(proc_stall), 128'd0);
        @(negedge clk); proc_write = 1'b0; proc_read = 1'b1; proc_addr = 30'h33; #1;
        chk("rw_miss_stall", 128'(proc_stall), 128'd1);
        @(negedge clk); #1;
        chk("rw_l2write", 128'(l2_write), 128'd1);
        chk("rw_word3", 128'(l2_wdata[127:96]), 128'h5555AAAA);
        @(negedge clk); reset = 1'b1; #1;
        chk("rw_rst_l2write", 128'(l2_write), 128'd0);
        chk("rw_rst_stall", 128'(proc_stall), 128'd0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rw_after_miss", 128'(proc_stall), 128'd1);
        chk("rw_after_l2read", 128'(l2_read), 128'd0);
        @(negedge clk); #1;
        chk("rw_alloc_l2read", 128'(l2_read), 128'd1);
        chk("rw_alloc_l2write", 128'(l2_write), 128'd0);
        chk("rw_alloc_addr", 128'(l2_addr), 128'h30);
        @(negedge clk); l2_ready = 1'b1; l2_rdata = LINE_B; #1;
        @(negedge clk); l2_ready = 1'b0; #1;
        chk("rw_rdata", 128'(proc_rdata), 128'hAAAA0003);
        chk("rw_stall_end", 128'(proc_stall), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
